// File: rtl/scandoubler_if.sv
// Video bundle between the ULA raster source and the scandoubler.
// The source (master) drives 15.6 kHz pixels in; the doubler (slave) returns 31.2 kHz video.
interface scandoubler_if;
  logic       ce;
  logic [8:0] rgbIn;
  logic       hSyncIn;
  logic       vSyncIn;
  logic [8:0] rgbOut;
  logic       hSyncOut;
  logic       vSyncOut;

  modport master (
    output ce, rgbIn, hSyncIn, vSyncIn,
    input  rgbOut, hSyncOut, vSyncOut
  );

  modport slave (
    input  ce, rgbIn, hSyncIn, vSyncIn,
    output rgbOut, hSyncOut, vSyncOut
  );
endinterface

// File: rtl/scandoubler.sv
// Line-doubling scan converter: each ULA line is captured into one bank of a
// two-bank line buffer while the other bank is replayed twice at the full clock rate.
module scandoubler #(
  parameter int HS_WIDTH = 54,
  parameter int MIN_LINE = 64,
  parameter int MAX_LINE = 512
) (
  input logic          clock,
  input logic          reset,
  scandoubler_if.slave vid
);
  localparam int         AW        = $clog2(MAX_LINE);
  localparam logic [9:0] X_MAX     = 10'(MAX_LINE - 1);
  localparam logic [9:0] HS_END    = 10'(HS_WIDTH);
  localparam logic [9:0] LINE_MIN  = 10'(MIN_LINE);
  localparam logic [9:0] LEN_RESET = 10'd456;

  logic [8:0]  r_mem [2*MAX_LINE];
  logic [8:0]  r_rd_data;
  logic [9:0]  r_in_x;
  logic [9:0]  r_out_x;
  logic [9:0]  r_line_len;
  logic        r_wr_bank;
  logic        r_hs_prev;
  logic        r_vs_prev;
  logic        r_vs_line;
  logic        r_active;
  logic        r_show;
  logic        r_hs_out;
  logic        r_vs_out;

  logic        w_new_line;
  logic        w_vs_sampled;
  logic        w_out_wrap;
  logic [AW:0] w_wr_addr;
  logic [AW:0] w_rd_addr;

  assign w_new_line   = vid.ce && r_hs_prev && !vid.hSyncIn && (r_in_x >= LINE_MIN);
  assign w_vs_sampled = vid.ce ? vid.vSyncIn : r_vs_prev;
  assign w_out_wrap   = w_new_line || (r_out_x >= r_line_len - 10'd1);
  // The pixel that carries the sync edge opens the fresh bank at address 0.
  assign w_wr_addr    = w_new_line ? {~r_wr_bank, {AW{1'b0}}} : {r_wr_bank, r_in_x[AW-1:0]};
  assign w_rd_addr    = {~r_wr_bank, r_out_x[AW-1:0]};

  // NOTE: the line buffer has no reset so it maps onto block RAM; stale
  // contents stay hidden behind r_show until a valid line has been captured.
  always_ff @(posedge clock) begin
    if (vid.ce) r_mem[w_wr_addr] <= vid.rgbIn;
    r_rd_data <= r_mem[w_rd_addr];
  end

  // NOTE: all state here is registered with non-blocking assignments, so every
  // term below sees the values from before this edge regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_x     <= '0;
      r_out_x    <= '0;
      r_line_len <= LEN_RESET;
      r_wr_bank  <= 1'b0;
      r_hs_prev  <= 1'b1;
      r_vs_prev  <= 1'b1;
      r_vs_line  <= 1'b1;
      r_active   <= 1'b0;
      r_show     <= 1'b0;
      r_hs_out   <= 1'b1;
      r_vs_out   <= 1'b1;
    end else begin
      if (vid.ce) begin
        r_hs_prev <= vid.hSyncIn;
        r_vs_prev <= vid.vSyncIn;
        if (w_new_line) begin
          r_line_len <= r_in_x;
          r_in_x     <= 10'd1;
          r_wr_bank  <= ~r_wr_bank;
          r_active   <= 1'b1;
        end else if (r_in_x != X_MAX) begin
          r_in_x <= r_in_x + 10'd1;
        end
      end

      r_out_x <= w_out_wrap ? '0 : r_out_x + 10'd1;
      if (w_out_wrap) r_vs_line <= w_vs_sampled;

      // One-clock delay on sync/blank keeps them aligned with the RAM read.
      r_hs_out <= !(r_active && (r_out_x < HS_END));
      r_vs_out <= !r_active || r_vs_line;
      r_show   <= r_active && (r_out_x >= HS_END) && (r_out_x < r_line_len);
    end
  end

  assign vid.rgbOut   = r_show ? r_rd_data : '0;
  assign vid.hSyncOut = r_hs_out;
  assign vid.vSyncOut = r_vs_out;
endmodule

// File: tb/tb_scandoubler.sv
// Directed bench for scandoubler: streams ULA lines (rgb = column, hsync low at
// columns 344..375), logs every output clock and checks the log against hand-derived values.
module tb_scandoubler;
  localparam int LOGN = 32768;
  localparam int LLEN = 456;

  logic clock = 1'b0;
  logic reset;

  scandoubler_if vid ();

  scandoubler dut (
    .clock (clock),
    .reset (reset),
    .vid   (vid)
  );

  always #5 clock = ~clock;

  logic [8:0] log_rgb [LOGN];
  logic       log_hs  [LOGN];
  logic       log_vs  [LOGN];
  int         ncyc  = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         starts [$];

  typedef struct {
    int         x;
    logic [8:0] rgb;
    logic       hs;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: log the outputs visible now, then drive inputs for the next edge.
  task automatic clk_step(input logic ce, input logic [8:0] rgb, input logic hs, input logic vs);
    @(negedge clock);
    if (ncyc < LOGN) begin
      log_rgb[ncyc] = vid.rgbOut;
      log_hs[ncyc]  = vid.hSyncOut;
      log_vs[ncyc]  = vid.vSyncOut;
    end
    ncyc++;
    vid.ce      = ce;
    vid.rgbIn   = rgb;
    vid.hSyncIn = hs;
    vid.vSyncIn = vs;
  endtask

  // Columns first..ncols-1 of a ULA line; a valid edge at column 344 makes
  // output position 0 appear in the log two clocks after its ce step.
  task automatic ula_line(input int first, input int ncols, input int hs_end, input int glitch,
                          input logic vs_a, input logic vs_b);
    logic hs;
    logic vs;
    for (int c = first; c < ncols; c++) begin
      hs = !((c >= 344 && c < hs_end) || c == glitch);
      vs = (c < 344) ? vs_a : vs_b;
      if (c == 344) starts.push_back(ncyc + 2);
      clk_step(1'b1, 9'(c), hs, vs);
      clk_step(1'b0, 9'(c), hs, vs);
    end
  endtask

  function automatic int count_hs_low(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) if (log_hs[i] === 1'b0) n++;
    return n;
  endfunction

  function automatic int count_vs_low(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) if (log_vs[i] === 1'b0) n++;
    return n;
  endfunction

  function automatic int idle_viol(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++)
      if (log_rgb[i] !== 9'd0 || log_hs[i] !== 1'b1 || log_vs[i] !== 1'b1) n++;
    return n;
  endfunction

  // Both replays of a full 456-pixel line whose address k holds column (344+k)%456.
  task automatic apply_table(input int s, input string tag);
    int idx;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 9; i++) begin
        idx = s + r * LLEN + vecs[i].x;
        check($sformatf("%s_r%0d_x%0d_rgb", tag, r, vecs[i].x), 32'(log_rgb[idx]), 32'(vecs[i].rgb));
        check($sformatf("%s_r%0d_x%0d_hs", tag, r, vecs[i].x), 32'(log_hs[idx]), 32'(vecs[i].hs));
      end
    end
  endtask

  int s;
  int rst_idx;

  initial begin
    vecs[0] = '{x: 0,   rgb: 9'd0,   hs: 1'b0};
    vecs[1] = '{x: 53,  rgb: 9'd0,   hs: 1'b0};
    vecs[2] = '{x: 54,  rgb: 9'd398, hs: 1'b1};
    vecs[3] = '{x: 100, rgb: 9'd444, hs: 1'b1};
    vecs[4] = '{x: 111, rgb: 9'd455, hs: 1'b1};
    vecs[5] = '{x: 112, rgb: 9'd0,   hs: 1'b1};
    vecs[6] = '{x: 113, rgb: 9'd1,   hs: 1'b1};
    vecs[7] = '{x: 200, rgb: 9'd88,  hs: 1'b1};
    vecs[8] = '{x: 455, rgb: 9'd343, hs: 1'b1};

    reset       = 1'b1;
    vid.ce      = 1'b0;
    vid.rgbIn   = '0;
    vid.hSyncIn = 1'b1;
    vid.vSyncIn = 1'b1;
    repeat (3) clk_step(1'b0, 9'd0, 1'b1, 1'b1);
    reset = 1'b0;

    repeat (4) ula_line(0, LLEN, 376, -1, 1'b1, 1'b1);  // lines 0..3
    ula_line(0, LLEN, 376, -1, 1'b1, 1'b0);             // line 4: vsync falls with hsync
    repeat (3) ula_line(0, LLEN, 376, -1, 1'b0, 1'b0);  // lines 5..7
    ula_line(0, LLEN, 376, -1, 1'b0, 1'b1);             // line 8: vsync rises
    ula_line(0, LLEN, 350, 354, 1'b1, 1'b1);            // line 9: glitch at inX=10
    ula_line(0, LLEN, 376, -1, 1'b1, 1'b1);             // line 10
    ula_line(0, 600, 376, -1, 1'b1, 1'b1);              // line 11: 600 pixels
    repeat (2) ula_line(0, LLEN, 376, -1, 1'b1, 1'b1);  // lines 12, 13
    ula_line(0, 444, 376, -1, 1'b1, 1'b1);              // line 14, cut short by reset

    rst_idx = starts[14] + 200;
    while (ncyc <= rst_idx) clk_step(1'b0, 9'd0, 1'b1, 1'b1);
    reset = 1'b1;
    repeat (2) clk_step(1'b0, 9'd0, 1'b1, 1'b1);
    reset = 1'b0;
    repeat (3) ula_line(0, LLEN, 376, -1, 1'b1, 1'b1);  // lines A, B, C
    repeat (4) clk_step(1'b0, 9'd0, 1'b1, 1'b1);

    // Reset state and idle hold until the first valid hsync.
    check("rst_rgb", 32'(log_rgb[2]), 32'd0);
    check("rst_hs", 32'(log_hs[2]), 32'd1);
    check("rst_vs", 32'(log_vs[2]), 32'd1);
    check("idle_before_first_line", idle_viol(0, starts[0]), 0);

    // Doubling of full lines, sync width and line length.
    apply_table(starts[1], "l2");
    apply_table(starts[2], "l3");
    check("hs_low_width", count_hs_low(starts[1], starts[1] + LLEN), 54);
    check("hs_low_two_lines", count_hs_low(starts[2], starts[2] + 2 * LLEN), 108);

    // Four ULA vsync lines become eight output lines, edges at outX=0.
    check("vs_before_fall", 32'(log_vs[starts[4] - 1]), 32'd1);
    check("vs_at_fall", 32'(log_vs[starts[4]]), 32'd0);
    check("vs_before_rise", 32'(log_vs[starts[8] - 1]), 32'd0);
    check("vs_at_rise", 32'(log_vs[starts[8]]), 32'd1);
    check("vs_low_count", count_vs_low(starts[3], starts[9]), 8 * LLEN);

    // Short glitch must not restart the line.
    s = starts[9];
    check("glitch_hs_count", count_hs_low(s, s + 3 * LLEN), 3 * 54);
    check("glitch_hs_911", 32'(log_hs[s + 911]), 32'd1);
    check("glitch_hs_912", 32'(log_hs[s + 912]), 32'd0);
    check("glitch_next_x60", 32'(log_rgb[starts[10] + 60]), 32'd404);
    check("glitch_next_x455", 32'(log_rgb[starts[10] + 455]), 32'd343);
    check("glitch_next_wrap", 32'(log_hs[starts[10] + LLEN]), 32'd0);

    // 600-pixel line: inX saturates, lineLen 511, second replay truncated.
    s = starts[12];
    check("long_x54", 32'(log_rgb[s + 54]), 32'd398);
    check("long_x200", 32'(log_rgb[s + 200]), 32'd32);
    check("long_x300", 32'(log_rgb[s + 300]), 32'd44);
    check("long_x510", 32'(log_rgb[s + 510]), 32'd254);
    check("long_hs_510", 32'(log_hs[s + 510]), 32'd1);
    check("long_hs_511", 32'(log_hs[s + 511]), 32'd0);
    check("long_r1_x100", 32'(log_rgb[s + 511 + 100]), 32'd444);
    check("long_hs_911", 32'(log_hs[s + 911]), 32'd1);
    check("long_truncate", 32'(log_hs[s + 912]), 32'd0);

    // Mid-line reset and recovery.
    check("midrst_rgb", 32'(log_rgb[rst_idx + 1]), 32'd0);
    check("midrst_hs", 32'(log_hs[rst_idx + 1]), 32'd1);
    check("midrst_vs", 32'(log_vs[rst_idx + 1]), 32'd1);
    check("idle_after_reset", idle_viol(rst_idx + 1, starts[15]), 0);
    check("post_first_hs_pre", 32'(log_hs[starts[15] - 1]), 32'd1);
    check("post_first_hs", 32'(log_hs[starts[15]]), 32'd0);
    apply_table(starts[16], "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
